// File: rtl/dp_ram_march_ctrl.sv
// March C- self-test controller driving one dp_ram port pair.
// Ports: clk/rst_n, start -> busy/done/pass/fail_*; ram_* drive the RAM.
module dp_ram_march_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] ram_data_mask_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [ADDR_WIDTH-1:0] AMAX = '1;
  localparam logic [ADDR_WIDTH-1:0] AONE = ADDR_WIDTH'(1);

  // Element states carry their march index as encoding.
  typedef enum logic [2:0] {
    E0   = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    E4   = 3'd4,
    E5   = 3'd5,
    IDLE = 3'd6,
    DONE = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic                  cmp_q, cmp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [2:0]            felem_q, felem_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;

  logic                  down;
  logic                  next_down;
  logic                  last;
  logic                  exp_one;
  logic                  wr_one;
  logic [DATA_WIDTH-1:0] diff;

  assign down      = (state_q == E3) || (state_q == E4);
  assign next_down = (state_q == E2) || (state_q == E3);
  assign last      = down ? (addr_q == '0) : (addr_q == AMAX);
  assign exp_one   = (state_q == E2) || (state_q == E4);
  assign wr_one    = (state_q == E1) || (state_q == E3);
  assign diff      = ram_data_out ^ {DATA_WIDTH{exp_one}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmp_q   <= 1'b0;
      addr_q  <= '0;
      pass_q  <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      faddr_q <= faddr_d;
      felem_q <= felem_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmp_d       = cmp_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    faddr_d     = faddr_q;
    felem_d     = felem_q;
    fdata_d     = fdata_q;
    ram_rd_en   = 1'b0;
    ram_wr_en   = 1'b0;
    ram_data_in = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = E0;
          cmp_d   = 1'b0;
          addr_d  = '0;
          pass_d  = 1'b0;
          faddr_d = '0;
          felem_d = '0;
          fdata_d = '0;
        end
      end
      E0: begin
        ram_wr_en = 1'b1;
        if (last) begin
          state_d = E1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AONE;
        end
      end
      E1, E2, E3, E4, E5: begin
        if (!cmp_q) begin
          ram_rd_en = 1'b1;
          cmp_d     = 1'b1;
        end else begin
          cmp_d = 1'b0;
          if (diff != '0) begin
            // First mismatch: freeze the report, skip the write.
            faddr_d = addr_q;
            felem_d = state_q;
            fdata_d = diff;
            pass_d  = 1'b0;
            state_d = DONE;
            addr_d  = '0;
          end else begin
            ram_wr_en   = (state_q != E5);
            ram_data_in = {DATA_WIDTH{wr_one}};
            if (!last) begin
              addr_d = down ? addr_q - AONE : addr_q + AONE;
            end else if (state_q == E5) begin
              state_d = DONE;
              pass_d  = 1'b1;
              addr_d  = '0;
            end else begin
              state_d = state_e'(state_q + 3'd1);
              addr_d  = next_down ? AMAX : '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy             = (state_q != IDLE) && (state_q != DONE);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign fail_addr        = faddr_q;
  assign fail_elem        = felem_q;
  assign fail_data        = fdata_q;
  assign ram_rd_addr      = addr_q;
  assign ram_wr_addr      = addr_q;
  assign ram_data_mask_in = '1;

endmodule

// File: tb/tb_dp_ram_march_ctrl.sv
// Scoreboard bench for dp_ram_march_ctrl with a faulty-RAM model.
// Expected RAM accesses and results come from a loop-level March C- model.
module tb_dp_ram_march_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
  logic          ram_rd_en, ram_wr_en;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] ram_data_in, ram_data_mask_in;
  logic [DW-1:0] ram_data_out = '0;

  always #5 clk = ~clk;

  dp_ram_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
    .ram_data_in(ram_data_in), .ram_data_mask_in(ram_data_mask_in),
    .ram_data_out(ram_data_out)
  );

  int checks = 0;
  int errors = 0;
  bit abort = 1'b0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM with an optional single stuck bit
  logic [DW-1:0] mem [N];
  bit            f_en = 1'b0;
  logic [AW-1:0] f_addr = '0;
  int            f_bit = 0;
  bit            f_val = 1'b0;

  function automatic logic [DW-1:0] rd_word(logic [DW-1:0] w, logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = w;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_rd_en) ram_data_out <= rd_word(mem[ram_rd_addr], ram_rd_addr);
    if (ram_wr_en)
      mem[ram_wr_addr] <= (mem[ram_wr_addr] & ~ram_data_mask_in)
                        | (ram_data_in & ram_data_mask_in);
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct packed {
    logic          pass;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    logic [DW-1:0] data;
    logic [31:0]   cycles;
  } res_t;

  op_t  expq[$];
  res_t resq[$];

  // March C- over a plain array; -1 means "no read"/"no write".
  task automatic model_test();
    int rdp[6] = '{-1, 0, 1, 0, 1, 0};
    int wrp[6] = '{0, 1, 0, 1, 0, -1};
    bit dn[6]  = '{0, 0, 0, 1, 1, 0};
    logic [DW-1:0] m [N];
    logic [DW-1:0] expw, got;
    logic [AW-1:0] a;
    op_t  op;
    res_t r;
    int   cyc;
    cyc = 0;
    r = '0;
    r.pass = 1'b1;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = dn[e] ? AW'(N - 1 - k) : AW'(k);
        if (rdp[e] >= 0) begin
          expw = (rdp[e] == 1) ? '1 : '0;
          op.wr = 1'b0; op.addr = a; op.data = '0;
          expq.push_back(op);
          got = rd_word(m[a], a);
          cyc += 2;
          if (got !== expw) begin
            r.pass = 1'b0;
            r.addr = a;
            r.elem = 3'(e);
            r.data = got ^ expw;
            r.cycles = cyc;
            resq.push_back(r);
            return;
          end
        end else begin
          cyc += 1;
        end
        if (wrp[e] >= 0) begin
          op.wr = 1'b1; op.addr = a;
          op.data = (wrp[e] == 1) ? '1 : '0;
          expq.push_back(op);
          m[a] = op.data;
        end
      end
    end
    r.cycles = cyc;
    resq.push_back(r);
  endtask

  // Monitor: pops expected RAM ops and results as the DUT presents them
  initial begin
    bit   busy_p, done_p;
    int   bcnt;
    op_t  eo;
    res_t er;
    busy_p = 1'b0; done_p = 1'b0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (ram_rd_en || ram_wr_en) begin
        chk(!(ram_rd_en && ram_wr_en), "one_access",
            {ram_rd_en, ram_wr_en}, 2'b00);
        chk(expq.size() != 0, "unexpected_access",
            {ram_wr_en, ram_wr_addr, ram_rd_addr}, 0);
        if (expq.size() != 0) begin
          eo = expq.pop_front();
          chk(ram_wr_en == eo.wr, "op_kind", ram_wr_en, eo.wr);
          if (eo.wr) begin
            chk(ram_wr_addr == eo.addr, "wr_addr", ram_wr_addr, eo.addr);
            chk(ram_data_in == eo.data, "wr_data", ram_data_in, eo.data);
          end else begin
            chk(ram_rd_addr == eo.addr, "rd_addr", ram_rd_addr, eo.addr);
          end
        end
      end
      if (busy && !busy_p) begin
        chk({pass, fail_addr, fail_elem, fail_data} == '0, "start_clear",
            {pass, fail_addr, fail_elem, fail_data}, 0);
        bcnt = 0;
      end
      if (busy) bcnt++;
      if (busy_p && !busy && !abort) chk(done, "done_after_busy", done, 1);
      if (done && !done_p) begin
        chk(resq.size() != 0, "unexpected_done", done, 0);
        if (resq.size() != 0) begin
          er = resq.pop_front();
          chk(pass == er.pass, "pass", pass, er.pass);
          chk(bcnt == er.cycles, "busy_cycles", bcnt, er.cycles);
          if (!er.pass) begin
            chk(fail_addr == er.addr, "fail_addr", fail_addr, er.addr);
            chk(fail_elem == er.elem, "fail_elem", fail_elem, er.elem);
            chk(fail_data == er.data, "fail_data", fail_data, er.data);
          end
        end
      end
      busy_p = busy;
      done_p = done;
    end
  end

  task automatic chk_idle(input string tag);
    chk(!busy && !done, {tag, "_busy_done"}, {busy, done}, 0);
    chk({pass, fail_addr, fail_elem, fail_data} == '0, {tag, "_fail"},
        {pass, fail_addr, fail_elem, fail_data}, 0);
    chk(!ram_rd_en && !ram_wr_en, {tag, "_en"}, {ram_rd_en, ram_wr_en}, 0);
    chk({ram_rd_addr, ram_wr_addr, ram_data_in} == '0, {tag, "_addr_data"},
        {ram_rd_addr, ram_wr_addr, ram_data_in}, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(done, "done_timeout", n, 400);
    if (!done) begin
      expq.delete();
      resq.delete();
    end
  endtask

  task automatic set_fault(input bit fe, input int fa, input int fb, input bit fv);
    f_en = fe;
    f_addr = AW'(fa);
    f_bit = fb;
    f_val = fv;
  endtask

  task automatic run_test();
    model_test();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("in_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");
    chk(ram_data_mask_in == '1, "mask", ram_data_mask_in, 8'hFF);

    // Fault-free run: 88 busy cycles, pass
    set_fault(0, 0, 0, 0);
    run_test();

    // Address 5 bit 0 stuck-at-1: caught in element 1
    set_fault(1, 5, 0, 1);
    run_test();

    // Random fault mix
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 2);
      set_fault(k != 0, $urandom_range(0, N - 1), $urandom_range(0, DW - 1), k == 1);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      run_test();
    end

    // Reset during element 2 aborts with no further accesses
    set_fault(0, 0, 0, 0);
    model_test();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (24 + $urandom_range(0, 15)) @(posedge clk);
    #1 abort = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    expq.delete();
    resq.delete();
    @(negedge clk);
    chk_idle("abort");
    repeat (20) @(negedge clk);
    chk(!busy && !done, "abort_stays_idle", {busy, done}, 0);
    abort = 1'b0;

    // Start held high: one failing test, then an immediate rerun
    set_fault(1, $urandom_range(0, N - 1), $urandom_range(0, DW - 1), 1);
    model_test();
    model_test();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    wait_done();
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk(busy && !done, "restart_after_done", {busy, done}, 2'b10);
    wait_done();

    repeat (5) @(negedge clk);
    chk(expq.size() == 0, "ops_left", expq.size(), 0);
    chk(resq.size() == 0, "results_left", resq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0t expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
